// File: rtl/cordic_angle_prep.sv
// Range-reduces an IEEE754 single angle in degrees to [-90,+90] and scales it to
// signed Q2.14 radians plus a cosine flip code. Optional macro: CORDIC_ANGLE_PREP_ROUND_EN.
module cordic_angle_prep #(
    parameter int          OUT_W    = 16,
    parameter int          OUT_FRAC = 14,
    parameter logic [31:0] K_RAD    = 32'd74961321
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [31:0]      angle_ieee754,
    output logic             busy,
    output logic             valid_out,
    output logic [OUT_W-1:0] angle_q,
    output logic [2:0]       flip_out,
    output logic             err
);

    localparam logic [30:0] DEG90  = 31'(90) << 16;
    localparam logic [30:0] DEG270 = 31'(270) << 16;
    localparam logic [30:0] DEG360 = 31'(360) << 16;
    localparam logic signed [31:0] DEG180_S = 32'sd180 <<< 16;
    localparam logic signed [31:0] DEG360_S = 32'sd360 <<< 16;
    localparam int SHIFT = 48 - OUT_FRAC;
`ifdef CORDIC_ANGLE_PREP_ROUND_EN
    localparam logic signed [63:0] ROUND_ADD = 64'sd1 <<< (SHIFT - 1);
`else
    localparam logic signed [63:0] ROUND_ADD = 64'sd0;
`endif

    // RED6..SIGN must stay consecutive: the reduction states advance by +1.
    typedef enum logic [3:0] {
        IDLE, UNPACK, ALIGN,
        RED6, RED5, RED4, RED3, RED2, RED1, RED0,
        SIGN, FOLD, SCALE, DONE
    } state_t;

    state_t             state;
    logic               sign_reg;
    logic [7:0]         exp_reg;
    logic [22:0]        man_reg;
    logic               err_reg;
    logic               zero_reg;
    logic [30:0]        mag_reg;
    logic signed [31:0] fold_reg;
    logic [2:0]         flip_reg;

    logic [30:0]        red_val;
    logic signed [31:0] mag_s;
    logic signed [63:0] prod;
    logic signed [63:0] prod_rnd;

    always_comb begin
        red_val = DEG360;
        case (state)
            RED6:    red_val = DEG360 << 6;
            RED5:    red_val = DEG360 << 5;
            RED4:    red_val = DEG360 << 4;
            RED3:    red_val = DEG360 << 3;
            RED2:    red_val = DEG360 << 2;
            RED1:    red_val = DEG360 << 1;
            default: red_val = DEG360;
        endcase
    end

    assign mag_s    = $signed({1'b0, mag_reg});
    assign prod     = $signed({{32{fold_reg[31]}}, fold_reg}) * $signed({32'd0, K_RAD});
    assign prod_rnd = prod + ROUND_ADD;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            valid_out <= 1'b0;
            angle_q   <= '0;
            flip_out  <= 3'b001;
            err       <= 1'b0;
            sign_reg  <= 1'b0;
            exp_reg   <= '0;
            man_reg   <= '0;
            err_reg   <= 1'b0;
            zero_reg  <= 1'b0;
            mag_reg   <= '0;
            fold_reg  <= '0;
            flip_reg  <= 3'b001;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        sign_reg <= angle_ieee754[31];
                        exp_reg  <= angle_ieee754[30:23];
                        man_reg  <= angle_ieee754[22:0];
                        busy     <= 1'b1;
                        state    <= UNPACK;
                    end
                end
                UNPACK: begin
                    err_reg  <= (exp_reg == 8'hFF);
                    zero_reg <= (exp_reg == 8'h00);
                    state    <= ALIGN;
                end
                ALIGN: begin
                    // Unbiased exponent >= 15 means |angle| >= 32768 deg.
                    if (exp_reg >= 8'd142) begin
                        err_reg <= 1'b1;
                        mag_reg <= '0;
                    end else if (zero_reg) begin
                        mag_reg <= '0;
                    end else if (exp_reg >= 8'd134) begin
                        mag_reg <= 31'({1'b1, man_reg}) << (exp_reg - 8'd134);
                    end else begin
                        mag_reg <= 31'({1'b1, man_reg}) >> (8'd134 - exp_reg);
                    end
                    state <= RED6;
                end
                RED6, RED5, RED4, RED3, RED2, RED1, RED0: begin
                    if (mag_reg >= red_val)
                        mag_reg <= mag_reg - red_val;
                    state <= state_t'(state + 4'd1);
                end
                SIGN: begin
                    if (sign_reg && (mag_reg != '0))
                        mag_reg <= DEG360 - mag_reg;
                    state <= FOLD;
                end
                FOLD: begin
                    if (mag_reg <= DEG90) begin
                        fold_reg <= mag_s;
                        flip_reg <= 3'b001;
                    end else if (mag_reg < DEG270) begin
                        fold_reg <= DEG180_S - mag_s;
                        flip_reg <= 3'b111;
                    end else begin
                        fold_reg <= mag_s - DEG360_S;
                        flip_reg <= 3'b001;
                    end
                    state <= SCALE;
                end
                SCALE: begin
                    angle_q   <= err_reg ? '0 : OUT_W'(prod_rnd >>> SHIFT);
                    flip_out  <= err_reg ? 3'b001 : flip_reg;
                    err       <= err_reg;
                    valid_out <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    valid_out <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_angle_prep.sv
// Randomized and directed bench for cordic_angle_prep against an arithmetic reference
// model (float decode, modulo reduction, fold, fixed-point scale).
module tb_cordic_angle_prep;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] angle_ieee754 = '0;
    logic        busy;
    logic        valid_out;
    logic [15:0] angle_q;
    logic [2:0]  flip_out;
    logic        err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int vo_count = 0;
    longint last_q = 0;

    typedef struct {
        logic [31:0] bits;
        longint      q;
        longint      flip;
        longint      err;
        int          acc;
    } exp_t;
    exp_t exp_q[$];

    cordic_angle_prep dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .angle_ieee754(angle_ieee754),
        .busy(busy), .valid_out(valid_out), .angle_q(angle_q), .flip_out(flip_out), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: exact float value in Q.16 (truncated), modulo 360, sign, fold, scale.
    function automatic void model(input logic [31:0] b, output longint q,
                                  output longint f, output longint e);
        longint sig, mag, red, a, p;
        int sh;
        q = 0; f = 1; e = 0; mag = 0;
        sig = longint'({1'b1, b[22:0]});
        sh = int'(b[30:23]) - 134;
        if (b[30:23] == 8'hFF || sh > 20) begin
            e = 1;
        end else begin
            if (b[30:23] == 8'h00) mag = 0;
            else if (sh >= 0) mag = sig << sh;
            else if (sh > -40) mag = sig >> (-sh);
            else mag = 0;
            if (mag >= (longint'(32768) << 16)) e = 1;
        end
        if (e == 0) begin
            red = mag % (360 * 65536);
            if (b[31] && red != 0) red = 360 * 65536 - red;
            if (red <= 90 * 65536) begin a = red; f = 1; end
            else if (red < 270 * 65536) begin a = 180 * 65536 - red; f = -1; end
            else begin a = red - 360 * 65536; f = 1; end
            p = a * 74961321;
`ifdef CORDIC_ANGLE_PREP_ROUND_EN
            p = p + (longint'(1) << 33);
`endif
            q = p >>> 34;
        end
    endfunction

    function automatic logic [31:0] int_to_float(input int d);
        int e;
        if (d == 0) return 32'h0;
        e = 0;
        while ((d >> (e + 1)) != 0) e++;
        return {1'b0, 8'(127 + e), 23'((d << (23 - e)) & 32'h7FFFFF)};
    endfunction

    // Single compare process: every valid_out pulse is matched against the model queue.
    always @(negedge clk) begin
        if (rst && valid_out) begin
            vo_count++;
            if (exp_q.size() == 0) begin
                chk("unexpected_valid_out", 1, 0);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                chk("angle_q", longint'($signed(angle_q)), x.q);
                chk("flip_out", longint'($signed(flip_out)), x.flip);
                chk("err", longint'(err), x.err);
                chk("latency", longint'(cyc - x.acc), 12);
                chk("busy_at_valid", longint'(busy), 1);
                last_q = x.q;
            end
        end
    end

    task automatic send(input logic [31:0] bits);
        exp_t x;
        int n;
        n = 0;
        while (busy && n < 50) begin @(negedge clk); n++; end
        if (busy) chk("idle_timeout", 1, 0);
        model(bits, x.q, x.flip, x.err);
        x.bits = bits;
        angle_ieee754 = bits;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        x.acc = cyc;
        exp_q.push_back(x);
        chk("busy_after_accept", longint'(busy), 1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin @(negedge clk); n++; end
        if (exp_q.size() != 0) begin
            chk("done_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_valid_out"}, longint'(valid_out), 0);
        chk({tag, "_angle_q"}, longint'($signed(angle_q)), 0);
        chk({tag, "_flip_out"}, longint'($signed(flip_out)), 1);
        chk({tag, "_err"}, longint'(err), 0);
    endtask

    localparam int NLIT = 8;
    logic [31:0] lit_bits [NLIT] = '{32'h41F00000, 32'h43160000, 32'hC1F00000, 32'h42B40000,
                                     32'h43870000, 32'h44340000, 32'h7FC00000, 32'h471C4000};
`ifdef CORDIC_ANGLE_PREP_ROUND_EN
    longint lit_q [NLIT] = '{8579, 8579, -8579, 25736, -25736, 0, 0, 0};
`else
    longint lit_q [NLIT] = '{8578, 8578, -8579, 25735, -25736, 0, 0, 0};
`endif
    longint lit_f [NLIT] = '{1, -1, 1, 1, 1, 1, 1, 1};
    longint lit_e [NLIT] = '{0, 0, 0, 0, 0, 0, 1, 1};

    logic [31:0] edge_bits [8] = '{32'h80000000, 32'h43B40000, 32'hC3B40000, 32'h00000001,
                                   32'h46FFFFFE, 32'h47000000, 32'hFF800000, 32'h3F800000};

    initial begin
        longint mq, mf, me;
        int vo_before;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        // Literal expectations pin the model, then drive the same vectors.
        for (int i = 0; i < NLIT; i++) begin
            model(lit_bits[i], mq, mf, me);
            chk("model_q", mq, lit_q[i]);
            chk("model_flip", mf, lit_f[i]);
            chk("model_err", me, lit_e[i]);
            send(lit_bits[i]);
            wait_done();
            $display("txn lit bits=%08h angle_q=%0d flip=%0d err=%0d", lit_bits[i],
                     $signed(angle_q), $signed(flip_out), err);
        end

        for (int i = 0; i < 8; i++) begin
            send(edge_bits[i]);
            wait_done();
            $display("txn edge bits=%08h angle_q=%0d flip=%0d err=%0d", edge_bits[i],
                     $signed(angle_q), $signed(flip_out), err);
        end

        // Re-pulse while busy must be ignored.
        send(32'h41F00000);
        repeat (3) @(negedge clk);
        vo_before = vo_count;
        angle_ieee754 = 32'h43870000;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        wait_done();
        repeat (20) @(negedge clk);
        chk("single_valid_out", vo_count - vo_before, 1);
        chk("hold_angle_q", longint'($signed(angle_q)), last_q);
        $display("txn repulse angle_q=%0d", $signed(angle_q));

        // Asynchronous reset mid-conversion aborts and clears outputs at once.
        send(32'h43160000);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        exp_q.delete();
        #1 chk_reset_outputs("abort");
        vo_before = vo_count;
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_valid", vo_count - vo_before, 0);
        $display("txn abort valid_out_count=%0d", vo_count - vo_before);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] b;
            int sel;
            sel = $urandom_range(99, 0);
            if (sel < 70) b = {1'($urandom), 8'($urandom_range(145, 100)), 23'($urandom)};
            else if (sel < 85) b = $urandom;
            else b = edge_bits[$urandom_range(7, 0)];
            send(b);
            wait_done();
            $display("txn rand bits=%08h angle_q=%0d flip=%0d err=%0d", b,
                     $signed(angle_q), $signed(flip_out), err);
        end

        // Sweep against a real-valued radian reference.
        for (int d = 0; d < 360; d++) begin
            int fd, rq, diff, ef;
            real r;
            send(int_to_float(d));
            wait_done();
            fd = (d <= 90) ? d : (d < 270) ? 180 - d : d - 360;
            ef = (d > 90 && d < 270) ? -1 : 1;
            r = fd * 3.14159265358979 / 180.0 * 16384.0;
            rq = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
            diff = int'($signed(angle_q)) - rq;
            if (diff < 0) diff = -diff;
            checks++;
            if (diff > 1) begin
                failures++;
                $display("FAIL sweep_angle deg=%0d actual=%0d required=%0d+-1", d,
                         $signed(angle_q), rq);
            end
            chk("sweep_flip", longint'($signed(flip_out)), ef);
            $display("txn sweep deg=%0d angle_q=%0d flip=%0d", d, $signed(angle_q),
                     $signed(flip_out));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
